// File: rtl/right_rotate_rx_pkg.sv
// right_rotate_rx_pkg: shared FSM state type and counter width helper for right_rotate_rx.
package right_rotate_rx_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} rx_state_t;
  function automatic int cnt_w(input int dw);
    return $clog2(dw) + 1;
  endfunction
endpackage

// File: rtl/rx_bit_cnt.sv
// rx_bit_cnt: clearable up-counter of received bits with terminal-count flag at DW-1.
module rx_bit_cnt #(
  parameter int DW = 4,
  parameter int CW = 3
) (
  input  logic clk,
  input  logic async_rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge async_rst)
    if (async_rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = cnt == CW'(DW - 1);
endmodule

// File: rtl/right_rotate_rx.sv
// right_rotate_rx: LSB-first serial-to-parallel receiver; RIGHT_ROTATE_RX_PARITY_EN adds an even-parity bit.
module right_rotate_rx
  import right_rotate_rx_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          async_rst,
  input  logic          start,
  input  logic          en,
  input  logic          sin,
  output logic [DW-1:0] q,
  output logic          valid,
  output logic          busy,
  output logic          perr
);
  localparam int CW = cnt_w(DW);
  rx_state_t state, nxt;
  logic [DW-1:0] shreg;
  logic tc, shift, done;
  assign shift = state == S_SHIFT && en && !start;
`ifdef RIGHT_ROTATE_RX_PARITY_EN
  assign done = state == S_PAR && en && !start;
`else
  assign done = shift && tc;
`endif
  assign busy = state != S_IDLE;
  rx_bit_cnt #(.DW(DW), .CW(CW)) u_cnt (
    .clk(clk),
    .async_rst(async_rst),
    .clr(start),
    .en(shift),
    .tc(tc)
  );
  always_ff @(posedge clk or posedge async_rst)
    if (async_rst) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (start) nxt = S_SHIFT;
`ifdef RIGHT_ROTATE_RX_PARITY_EN
    else if (shift && tc) nxt = S_PAR;
    else if (done) nxt = S_IDLE;
`else
    else if (done) nxt = S_IDLE;
`endif
  end
  always_ff @(posedge clk or posedge async_rst)
    if (async_rst) begin
      shreg <= '0;
      q     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= done;
      if (shift) shreg <= {sin, shreg[DW-1:1]};
`ifdef RIGHT_ROTATE_RX_PARITY_EN
      if (done) q <= shreg;
`else
      if (done) q <= {sin, shreg[DW-1:1]};
`endif
    end
`ifdef RIGHT_ROTATE_RX_PARITY_EN
  // Even parity over data plus the received parity bit; held until the next word.
  always_ff @(posedge clk or posedge async_rst)
    if (async_rst) perr <= 1'b0;
    else if (done) perr <= (^shreg) ^ sin;
`else
  assign perr = 1'b0;
`endif
endmodule

// File: tb/tb_right_rotate_rx.sv
// tb_right_rotate_rx: directed and randomized frames for right_rotate_rx against a right-rotate transmitter model.
module tb_right_rotate_rx;
  localparam int DW = 4;
`ifdef RIGHT_ROTATE_RX_PARITY_EN
  localparam int NB = DW + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int NB = DW;
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0, async_rst = 1'b1, start = 1'b0, en = 1'b0, sin = 1'b0;
  logic [DW-1:0] q;
  logic valid, busy, perr;
  logic [DW-1:0] q_exp = '0;
  logic perr_exp = 1'b0;
  int tests = 0, fails = 0, edges = 0, last_valid_edge = 0, e1 = 0;

  right_rotate_rx #(.DW(DW)) dut (
    .clk(clk), .async_rst(async_rst), .start(start), .en(en), .sin(sin),
    .q(q), .valid(valid), .busy(busy), .perr(perr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a frame and feed n random bits without finishing it.
  task automatic send_partial(input int n);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      sin = 1'($urandom);
      en = 1'b1;
      tick;
      en = 1'b0;
      chk("part_valid", valid, 1'b0);
      chk("part_q", q, q_exp);
    end
  endtask

  // Transmitter model: a right-rotate register loaded with w presents bit i on q[0] at shift i.
  task automatic run_frame(input logic [DW-1:0] w, input logic pbit, input int gap_at,
                           input int gap_len, input bit rnd);
    logic [DW-1:0] tx;
    int t0, gaps, g;
    tx = w;
    gaps = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    t0 = edges;
    chk("start_valid", valid, 1'b0);
    chk("start_busy", busy, 1'b1);
    for (int i = 0; i < NB; i++) begin
      g = rnd ? int'($urandom_range(0, 2)) : (i == gap_at ? gap_len : 0);
      for (int k = 0; k < g; k++) begin
        sin = 1'($urandom);
        tick;
        chk("gap_valid", valid, 1'b0);
        chk("gap_q", q, q_exp);
      end
      gaps += g;
      sin = (i < DW) ? tx[0] : pbit;
      tx = {tx[0], tx[DW-1:1]};
      en = 1'b1;
      tick;
      en = 1'b0;
      if (i < NB - 1) begin
        chk("bit_valid", valid, 1'b0);
        chk("bit_busy", busy, 1'b1);
      end
    end
    q_exp = w;
    perr_exp = PAR ? ((^w) ^ pbit) : 1'b0;
    chk("done_valid", valid, 1'b1);
    chk("done_q", q, q_exp);
    chk("done_busy", busy, 1'b0);
    chk("done_perr", perr, perr_exp);
    chk("latency", edges - t0, NB + gaps);
    last_valid_edge = edges;
  endtask

  task automatic idle_check;
    tick;
    chk("idle_valid", valid, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_q", q, q_exp);
    chk("idle_perr", perr, perr_exp);
  endtask

  initial begin
    #2;
    chk("rst_q", q, '0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_perr", perr, 1'b0);
    tick;
    async_rst = 1'b0;
    tick;
    // en with no frame in progress must be ignored
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sin = 1'($urandom);
      idle_check();
    end
    en = 1'b0;
    run_frame(4'hB, 1'b1, 0, 0, 1'b0);
    idle_check();
    run_frame(4'hB, 1'b1, 2, 3, 1'b0);
    idle_check();
    send_partial(2);
    run_frame(4'h2, 1'b1, 0, 0, 1'b0);
    idle_check();
    send_partial(2);
    async_rst = 1'b1;
    #4;
    q_exp = '0;
    perr_exp = 1'b0;
    chk("arst_q", q, '0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_valid", valid, 1'b0);
    async_rst = 1'b0;
    idle_check();
    run_frame(4'h9, 1'b0, 0, 0, 1'b0);
    idle_check();
    run_frame(4'hB, 1'b1, 0, 0, 1'b0);
    e1 = last_valid_edge;
    run_frame(4'h6, 1'b0, 0, 0, 1'b0);
    chk("b2b_spacing", last_valid_edge - e1, NB + 1);
    idle_check();
    run_frame(4'hB, 1'b1, 0, 0, 1'b0);
    idle_check();
    run_frame(4'hB, 1'b0, 0, 0, 1'b0);
    idle_check();
    for (int n = 0; n < 25; n++) begin
      logic [DW-1:0] w;
      logic pb;
      w = DW'($urandom);
      pb = 1'($urandom);
      if ($urandom_range(0, 3) == 0) send_partial(int'($urandom_range(1, NB - 1)));
      run_frame(w, pb, 0, 0, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        en = 1'($urandom);
        sin = 1'($urandom);
        idle_check();
        en = 1'b0;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
